// File: rtl/matmul_seq_ctrl_if.sv
// Host, memory-bank, MAC and result-slot signals of the 3x3 matmul sequencer.
// The slave modport is the controller side; master is the host/bench side.
interface matmul_seq_ctrl_if #(
    parameter int unsigned DW = 4
);
    logic          start;
    logic [1:0]    row_w;
    logic [1:0]    col_w;
    logic [1:0]    row_x;
    logic [1:0]    col_x;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_clear;
    logic          mem_we_w;
    logic          mem_we_x;
    logic [3:0]    mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mac_clear;
    logic          mac_ld;
    logic [3:0]    w_base;
    logic [3:0]    x_base;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, row_w, col_w, row_x, col_x, in_valid, in_data, out_ready,
        output in_ready, mem_clear, mem_we_w, mem_we_x, mem_waddr, mem_wdata,
               mac_clear, mac_ld, w_base, x_base, out_valid, out_row, out_col,
               busy, done, err
    );

    modport master (
        output start, row_w, col_w, row_x, col_x, in_valid, in_data, out_ready,
        input  in_ready, mem_clear, mem_we_w, mem_we_x, mem_waddr, mem_wdata,
               mac_clear, mac_ld, w_base, x_base, out_valid, out_row, out_col,
               busy, done, err
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 3x3 matrix-multiply datapath: clears the bank, loads W then X
// from the host, then walks every C[i][j] in row-major order through the MAC.
module matmul_seq_ctrl #(
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned DW      = 4
) (
    input logic              clk,
    input logic              rst_n,
    matmul_seq_ctrl_if.slave ctrl_if
);

    typedef enum logic [3:0] {
        StIdle, StClear, StLoadW, StLoadX, StMacClr, StMacLd, StWait, StOut, StDone, StErr
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] row_w_q, row_w_d, col_w_q, col_w_d;
    logic [1:0] row_x_q, row_x_d, col_x_q, col_x_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] i_q, i_d, j_q, j_d;
    logic [2:0] wait_q, wait_d;
    logic       err_q, err_d;

    logic [3:0]    w_total, x_total, w_row_base;
    logic [DW-1:0] pass_data;

    assign w_total    = 4'(row_w_q) * 4'(col_w_q);
    assign x_total    = 4'(row_x_q) * 4'(col_x_q);
    assign w_row_base = 4'(i_q) * 4'(col_w_q);

    // Write data is a pure pass-through of the host element.
    assign pass_data         = ctrl_if.in_data;
    assign ctrl_if.mem_wdata = pass_data;

    // State, job dimensions and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_w_q <= '0;
            col_w_q <= '0;
            row_x_q <= '0;
            col_x_q <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_w_q <= row_w_d;
            col_w_q <= col_w_d;
            row_x_q <= row_x_d;
            col_x_q <= col_x_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state and strobe decode; every output idles at zero outside its state.
    always_comb begin
        state_d = state_q;
        row_w_d = row_w_q;
        col_w_d = col_w_q;
        row_x_d = row_x_q;
        col_x_d = col_x_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        wait_d  = wait_q;
        err_d   = err_q;

        ctrl_if.in_ready  = 1'b0;
        ctrl_if.mem_clear = 1'b0;
        ctrl_if.mem_we_w  = 1'b0;
        ctrl_if.mem_we_x  = 1'b0;
        ctrl_if.mem_waddr = '0;
        ctrl_if.mac_clear = 1'b0;
        ctrl_if.mac_ld    = 1'b0;
        ctrl_if.w_base    = '0;
        ctrl_if.x_base    = '0;
        ctrl_if.out_valid = 1'b0;
        ctrl_if.out_row   = '0;
        ctrl_if.out_col   = '0;
        ctrl_if.done      = 1'b0;
        ctrl_if.busy      = (state_q != StIdle);
        ctrl_if.err       = err_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_if.start) begin
                    row_w_d = ctrl_if.row_w;
                    col_w_d = ctrl_if.col_w;
                    row_x_d = ctrl_if.row_x;
                    col_x_d = ctrl_if.col_x;
                    err_d   = 1'b0;
                    if (ctrl_if.row_w == 2'd0 || ctrl_if.col_w == 2'd0 ||
                        ctrl_if.row_x == 2'd0 || ctrl_if.col_x == 2'd0 ||
                        ctrl_if.col_w != ctrl_if.row_x) begin
                        state_d = StErr;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StClear: begin
                ctrl_if.mem_clear = 1'b1;
                cnt_d             = '0;
                state_d           = StLoadW;
            end
            StLoadW: begin
                ctrl_if.in_ready  = 1'b1;
                ctrl_if.mem_we_w  = ctrl_if.in_valid;
                ctrl_if.mem_waddr = cnt_q;
                if (ctrl_if.in_valid) begin
                    if (cnt_q == w_total - 4'd1) begin
                        cnt_d   = '0;
                        state_d = StLoadX;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StLoadX: begin
                ctrl_if.in_ready  = 1'b1;
                ctrl_if.mem_we_x  = ctrl_if.in_valid;
                ctrl_if.mem_waddr = cnt_q;
                if (ctrl_if.in_valid) begin
                    if (cnt_q == x_total - 4'd1) begin
                        cnt_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = StMacClr;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StMacClr: begin
                ctrl_if.mac_clear = 1'b1;
                state_d           = StMacLd;
            end
            StMacLd: begin
                ctrl_if.mac_ld = 1'b1;
                ctrl_if.w_base = w_row_base;
                ctrl_if.x_base = 4'(j_q);
                wait_d         = 3'(MAC_LAT);
                state_d        = StWait;
            end
            StWait: begin
                // Exactly MAC_LAT cycles are spent here.
                wait_d = wait_q - 3'd1;
                if (wait_q <= 3'd1) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                ctrl_if.out_valid = 1'b1;
                ctrl_if.out_row   = i_q;
                ctrl_if.out_col   = j_q;
                if (ctrl_if.out_ready) begin
                    if (j_q != col_x_q - 2'd1) begin
                        j_d     = j_q + 2'd1;
                        state_d = StMacClr;
                    end else if (i_q != row_w_q - 2'd1) begin
                        j_d     = '0;
                        i_d     = i_q + 2'd1;
                        state_d = StMacClr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                ctrl_if.done = 1'b1;
                state_d      = StIdle;
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
